// File: rtl/alu_div_seq.sv
// Sequential 8-bit unsigned restoring divider driving an external combinational ALU.
// Latency: 9 edges from accept for a nonzero divisor, 1 edge for divisor 0. Result held until out_ready.
module alu_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_i0,
    output logic [WIDTH-1:0] alu_i1,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [WIDTH-1:0]  shift;
    logic              take;
    logic [WIDTH-1:0]  r_nxt;
    logic [WIDTH-1:0]  q_nxt;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        alu_op  = 2'b00;
        alu_i0  = '0;
        alu_i1  = '0;
        shift   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        // A set R msb would mean the shifted value overflowed past D, so a
        // subtract is forced; the invariant keeps this bit clear in practice.
        take    = alu_cout | r_q[WIDTH-1];
        r_nxt   = take ? alu_o : shift;
        q_nxt   = {q_q[WIDTH-2:0], take};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                alu_op = 2'b01;
                alu_i0 = shift;
                alu_i1 = d_q;
                r_d    = r_nxt;
                q_d    = q_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quot_d  = q_nxt;
                    rem_d   = r_nxt;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: behavioural ALU plus a queue scoreboard checked by a monitor.
module tb_alu_div_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic [1:0] alu_op;
    logic [7:0] alu_i0;
    logic [7:0] alu_i1;
    logic [7:0] alu_o;
    logic       alu_cout;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   opcnt = 0;
    bit   prev_v = 0;
    bit   rand_rdy = 0;

    alu_div_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
        .alu_o(alu_o), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the external ALU
    always_comb begin
        alu_o    = 8'h00;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: {alu_cout, alu_o} = {1'b0, alu_i0} + {1'b0, alu_i1};
            2'b01: begin
                alu_o    = alu_i0 - alu_i1;
                alu_cout = (alu_i0 >= alu_i1);
            end
            2'b10: alu_o = alu_i0 & alu_i1;
            default: alu_o = alu_i0 ^ alu_i1;
        endcase
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", int'(n < 200), 1);
        if (b == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_valid || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(n < 400), 1);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 0;
            opcnt  = 0;
        end else begin
            if (alu_op == 2'b01) begin
                opcnt++;
                chk("r_invariant", int'(int'(alu_i0) < 2 * int'(alu_i1)), 1);
            end else begin
                chk("alu_idle", int'({alu_op, alu_i0, alu_i1}), 0);
            end
            if (out_valid) begin
                chk("in_ready_busy", int'(in_ready), 0);
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", int'(out_valid), 0);
                end else begin
                    e = sb[0];
                    if (!prev_v) begin
                        chk("latency", cyc - e.acc + 1, e.z ? 1 : 9);
                        chk("sub_cycles", opcnt, e.z ? 0 : 8);
                    end
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("div_by_zero", int'(div_by_zero), int'(e.z));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        opcnt = 0;
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        logic [7:0] a, b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        out_ready = 1'b1;
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        chk("rst_alu", int'({alu_op, alu_i0, alu_i1}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(8'd200, 8'd7);   drain();
        send(8'd255, 8'd1);   drain();
        send(8'd5,   8'd200); drain();
        send(8'd255, 8'd255); drain();
        send(8'd0,   8'd9);   drain();
        send(8'd77,  8'd0);   drain();

        // Backpressure with a second request queued behind the held result
        out_ready = 1'b0;
        send(8'd100, 8'd3);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_timeout", int'(n < 50), 1);
        fork
            send(8'd9, 8'd4);
        join_none
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset pulsed during ITER cycle 4
        send(8'd200, 8'd7);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_alu_op", int'(alu_op), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        send(8'd50, 8'd6);
        drain();

        // Randomised traffic with random consumer stalls
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: b = 8'd0;
                1: b = 8'($urandom_range(1, 15));
                default: b = 8'($urandom_range(0, 255));
            endcase
            send(a, b);
        end
        drain();
        rand_rdy = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
